// File: rtl/ysyx_24070016_idu_stage_if.sv
// Decode-stage bus: IFU-side instruction request, EXU-side decoded entry, and flush.
// A transfer happens on a rising edge where valid & ready are both 1 and flush is 0; the valid side holds its payload until then.
interface ysyx_24070016_idu_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [RW-1:0]   out_rs1;
  logic [RW-1:0]   out_rs2;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_func3;
  logic            out_func7b5;
  logic            out_rf_wen;
  logic            out_sel_rs2Isimm;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_is_branch;
  logic            out_is_jal;
  logic            out_is_jalr;
  logic            out_is_lui;
  logic            out_is_auipc;
  logic            out_ebreak;
  logic            out_ecall;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
    output out_func3, out_func7b5, out_rf_wen, out_sel_rs2Isimm,
    output out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr,
    output out_is_lui, out_is_auipc, out_ebreak, out_ecall, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
    input  out_func3, out_func7b5, out_rf_wen, out_sel_rs2Isimm,
    input  out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr,
    input  out_is_lui, out_is_auipc, out_ebreak, out_ecall, out_illegal
  );
endinterface

// File: rtl/ysyx_24070016_idu_stage.sv
// RV32I/RV32E decode stage: combinational decode captured into a 1- or 2-entry
// elastic buffer between IFU and EXU, with flush on redirect.
module ysyx_24070016_idu_stage #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int SKID   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24070016_idu_stage_if.slave    bus,
  output logic [1:0]                  state_dbg
);
  localparam int RW = $clog2(NR_REG);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      func3;
    logic            func7b5;
    logic            rf_wen;
    logic            sel_rs2Isimm;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            is_auipc;
    logic            ebreak;
    logic            ecall;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  function automatic logic reg_ok(input logic [4:0] idx);
    return {27'd0, idx} < 32'(NR_REG);
  endfunction

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = bus.in_inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic        legal, use_rd, use_rs1, use_rs2, illegal;
  logic        c_wen, c_sel, c_load, c_store, c_branch, c_jal, c_jalr, c_lui, c_auipc;
  logic        c_ecall, c_ebreak;
  logic [31:0] imm;
  dec_t        dec;

  always_comb begin
    legal    = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm      = '0;
    c_wen    = 1'b0;
    c_sel    = 1'b0;
    c_load   = 1'b0;
    c_store  = 1'b0;
    c_branch = 1'b0;
    c_jal    = 1'b0;
    c_jalr   = 1'b0;
    c_lui    = 1'b0;
    c_auipc  = 1'b0;
    c_ecall  = 1'b0;
    c_ebreak = 1'b0;
    // opc carries inst[1:0], so compressed encodings fall through to default
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; use_rd = 1'b1; imm = imm_u; c_lui = 1'b1; c_wen = 1'b1; c_sel = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; use_rd = 1'b1; imm = imm_u; c_auipc = 1'b1; c_wen = 1'b1; c_sel = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; use_rd = 1'b1; imm = imm_j; c_jal = 1'b1; c_wen = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        c_jalr = 1'b1; c_wen = 1'b1; c_sel = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm = imm_b; c_branch = 1'b1;
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; c_load = 1'b1; c_wen = 1'b1; c_sel = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 < 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
        c_store = 1'b1; c_sel = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; c_wen = 1'b1; c_sel = 1'b1;
      end
      OPC_OP: begin
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; c_wen = 1'b1;
      end
      OPC_FENCE: legal = 1'b1;
      OPC_SYSTEM: begin
        c_ecall  = (inst == 32'h0000_0073);
        c_ebreak = (inst == 32'h0010_0073);
        legal    = c_ecall | c_ebreak;
      end
      default: legal = 1'b0;
    endcase

    illegal = ~legal
            | (use_rd  & ~reg_ok(inst[11:7]))
            | (use_rs1 & ~reg_ok(inst[19:15]))
            | (use_rs2 & ~reg_ok(inst[24:20]));

    dec              = '0;
    dec.pc           = bus.in_pc;
    dec.rs1          = inst[15 +: RW];
    dec.rs2          = inst[20 +: RW];
    dec.rd           = inst[7 +: RW];
    dec.imm          = imm;
    dec.func3        = f3;
    dec.func7b5      = inst[30];
    dec.illegal      = illegal;
    dec.rf_wen       = c_wen    & ~illegal;
    dec.sel_rs2Isimm = c_sel    & ~illegal;
    dec.is_load      = c_load   & ~illegal;
    dec.is_store     = c_store  & ~illegal;
    dec.is_branch    = c_branch & ~illegal;
    dec.is_jal       = c_jal    & ~illegal;
    dec.is_jalr      = c_jalr   & ~illegal;
    dec.is_lui       = c_lui    & ~illegal;
    dec.is_auipc     = c_auipc  & ~illegal;
    dec.ecall        = c_ecall  & ~illegal;
    dec.ebreak       = c_ebreak & ~illegal;
  end

  state_t state;
  dec_t   out_q, skid_q;
  logic   in_ready, accept;

  // Without the skid entry, a full output register can only take a new entry as the old one leaves.
  assign in_ready = (SKID != 0) ? (~rst & (state != S_TWO))
                                : (~rst & ((state == S_EMPTY) | bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_q <= dec;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && bus.out_ready) begin
            out_q <= dec;
          end else if (accept) begin
            skid_q <= dec;
            state  <= S_TWO;
          end else if (bus.out_ready) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (bus.out_ready) begin
            out_q <= skid_q;
            state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign state_dbg            = state;
  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = (state != S_EMPTY);
  assign bus.out_pc           = out_q.pc;
  assign bus.out_rs1          = out_q.rs1;
  assign bus.out_rs2          = out_q.rs2;
  assign bus.out_rd           = out_q.rd;
  assign bus.out_imm          = out_q.imm;
  assign bus.out_func3        = out_q.func3;
  assign bus.out_func7b5      = out_q.func7b5;
  assign bus.out_rf_wen       = out_q.rf_wen;
  assign bus.out_sel_rs2Isimm = out_q.sel_rs2Isimm;
  assign bus.out_is_load      = out_q.is_load;
  assign bus.out_is_store     = out_q.is_store;
  assign bus.out_is_branch    = out_q.is_branch;
  assign bus.out_is_jal       = out_q.is_jal;
  assign bus.out_is_jalr      = out_q.is_jalr;
  assign bus.out_is_lui       = out_q.is_lui;
  assign bus.out_is_auipc     = out_q.is_auipc;
  assign bus.out_ebreak       = out_q.ebreak;
  assign bus.out_ecall        = out_q.ecall;
  assign bus.out_illegal      = out_q.illegal;
endmodule

// File: doc/ysyx_24070016_idu_stage.md
Name: ysyx_24070016_idu_stage

Overview:
Registered, handshaked RV32I/RV32E instruction-decode stage for the pipelined NPC, sitting between IFU and EXU. Extends the single-cycle addi-only decoder to the full RV32I base set: all immediate formats, the class controls EXU/LSU need, and illegal-instruction detection. A 2-entry elastic buffer lets it take backpressure without dropping or duplicating instructions. A flush input drops in-flight work on redirect.

Parameters:
XLEN, 32, datapath width of pc and imm; only 32 is supported.
NR_REG, 32, architectural register count; 32 = RV32I, 16 = RV32E; RW = $clog2(NR_REG).
SKID, 1, 1 = 2-entry buffer (full throughput under backpressure); 0 = single entry, in_ready = ~out_valid | out_ready.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-high.
flush  in  1  discard all buffered entries and the current input.
in_valid  in  1  IFU presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
in_inst  in  32  raw instruction.
in_pc  in  XLEN  instruction pc.
out_valid  out  1  decoded entry available.
out_ready  in  1  EXU consumes the entry this cycle.
out_pc  out  XLEN  pc of the entry.
out_rs1 / out_rs2 / out_rd  out  RW each  register indices.
out_imm  out  XLEN  sign-extended immediate.
out_func3  out  3  inst[14:12].
out_func7b5  out  1  inst[30].
out_rf_wen  out  1  register-file write enable.
out_sel_rs2Isimm  out  1  ALU operand B is imm.
out_is_load / out_is_store / out_is_branch / out_is_jal / out_is_jalr / out_is_lui / out_is_auipc  out  1 each  class flags.
out_ebreak / out_ecall  out  1 each  system-call flags.
out_illegal  out  1  instruction is not a legal decode.

Behaviour:
- Reset: out_valid = 0, skid empty, all payload outputs = 0, in_ready = 0 while rst = 1. in_ready = 1 on the first cycle after rst falls.
- Decode is combinational on in_inst and is captured at acceptance (in_valid & in_ready). Latency is 1 cycle from acceptance to out_valid.
- Payload is held stable while out_valid & ~out_ready. Inputs are never re-sampled after acceptance.
- Buffer states (SKID = 1): EMPTY, ONE (out reg valid), TWO (out + skid valid). in_ready = ~rst & (state != TWO).
  - EMPTY --accept--> ONE.
  - ONE: accept & out_ready -> ONE with the new entry.
  - ONE: accept & ~out_ready -> TWO, new entry goes to skid.
  - ONE: ~accept & out_ready -> EMPTY.
  - TWO: out_ready -> ONE, skid moves to out reg. No accept is possible in TWO.
- Ordering is strict FIFO. No entry is lost or duplicated.
- flush = 1: next state is EMPTY and any same-cycle input is dropped; flush has priority over accept and over out_ready. in_ready may be 1 during flush, but the handshake is void.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE = legal nop), SYSTEM.
- Immediate formats, all sign-extended from inst[31]:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI, AUIPC; inst[31:12] << 12.
  - J: JAL, bit0 = 0.
  - Other opcodes: imm = 0.
- out_sel_rs2Isimm = 1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC.
- out_rf_wen = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when ~illegal. rd = 0 still asserts wen; x0 write suppression is done in the RF.
- out_illegal = 1 for any of:
  - inst[1:0] != 2'b11, or unlisted opcode.
  - LOAD func3 in {011, 110, 111}; STORE func3 >= 011.
  - BRANCH func3 in {010, 011}; JALR func3 != 000.
  - OP func7 not 0000000, or func7 = 0100000 with func3 not in {000, 101}.
  - OP-IMM shift (func3 001/101) with an illegal func7.
  - SYSTEM other than exactly 0x00000073 (ecall) or 0x00100073 (ebreak).
  - Any used register field >= NR_REG. Fields truncate to RW bits in outputs.
- When illegal: all class flags, rf_wen and sel_rs2Isimm = 0; pc, fields and imm are still driven.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) at pc 0x80000000 with out_ready = 1 -> next cycle out_valid = 1, rd = 1, rs1 = 0, imm = 0x00000005, rf_wen = 1, sel_rs2Isimm = 1, illegal = 0.
- Immediate formats:
  - 0xFFF08113 -> imm = 0xFFFFFFFF.
  - sw 0x0020A423 -> is_store = 1, rs1 = 1, rs2 = 2, imm = 8, rf_wen = 0.
  - beq 0xFE000EE3 -> is_branch = 1, imm = 0xFFFFFFFC.
- Backpressure: stream pcs 0, 4, 8, 12 with out_ready low for 3 cycles -> in_ready drops after 2 accepts. Output order is 0, 4, 8, 12 with no gaps once out_ready = 1.
- Flush in state TWO with in_valid = 1 -> next cycle out_valid = 0, and the flushed input never appears at the output.
- Illegal: 0xFFFFFFFF and 0x00200073 -> illegal = 1, rf_wen = 0. With NR_REG = 16, 0x00100813 (addi x16) -> illegal = 1.
- ebreak 0x00100073 -> ebreak = 1, illegal = 0. rst asserted mid-stream -> out_valid = 0 and in_ready = 0 during rst.
